// File: rtl/bp_pkg.sv
// Shared types for the branch predict unit: saturating-counter encoding and BTB entry layout.
// Widths of the package struct match the default geometry; the top re-declares it per parameters.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int unsigned DEF_PC_W  = 9;
  localparam int unsigned DEF_TAG_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_PC_W-1:0]  target;
    logic                 is_jump;
    ctr_e                 ctr;
  } btb_entry_t;

  localparam ctr_e RESET_CTR = WNT;
  localparam ctr_e ALLOC_CTR = WT;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and EX-resolve signal bundle between the pipeline and the branch predict unit.
interface branch_predict_unit_if #(
  parameter int unsigned PC_W = 9
);
  logic [PC_W-1:0] f_pc;
  logic            f_pred_taken;
  logic [PC_W-1:0] f_pred_target;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic [31:0]     ex_imm;
  logic            ex_branch;
  logic            ex_jmp;
  logic            ex_jmpr;
  logic [31:0]     ex_alu_result;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;
  logic [31:0]     pc_imm;
  logic [31:0]     pc_four;
  logic            redirect;
  logic [31:0]     redirect_pc;
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;

  modport master (
    output f_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jmp, ex_jmpr, ex_alu_result,
           ex_pred_taken, ex_pred_target,
    input  f_pred_taken, f_pred_target, pc_imm, pc_four, redirect, redirect_pc,
           perf_branches, perf_mispredicts
  );

  modport slave (
    input  f_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_jmp, ex_jmpr, ex_alu_result,
           ex_pred_taken, ex_pred_target,
    output f_pred_taken, f_pred_target, pc_imm, pc_four, redirect, redirect_pc,
           perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/bp_sat_ctr2.sv
// Next state of a 2-bit saturating branch counter; 00 and 11 hold at the extremes.
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  ctr_e i_ctr,
  input  logic i_taken,
  output ctr_e o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    unique case (i_ctr)
      SNT: o_ctr = i_taken ? WNT : SNT;
      WNT: o_ctr = i_taken ? WT  : SNT;
      WT:  o_ctr = i_taken ? ST  : WNT;
      ST:  o_ctr = i_taken ? ST  : WT;
      default: o_ctr = i_ctr;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolver with a direct-mapped BTB (2-bit counters) for fetch prediction
// and 32-bit resolution / mispredict performance counters.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int unsigned PC_W        = 9,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  branch_predict_unit_if.slave io_bus
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic             is_jump;
    ctr_e             ctr;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, is_jump: 1'b0,
                                     ctr: RESET_CTR};

  entry_t r_btb [BTB_ENTRIES];
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  // Fetch lookup
  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  entry_t           w_f_entry;
  logic             w_f_hit;

  assign w_f_idx   = io_bus.f_pc[IDX_W+1:2];
  assign w_f_tag   = io_bus.f_pc[PC_W-1:IDX_W+2];
  assign w_f_entry = r_btb[w_f_idx];
  assign w_f_hit   = w_f_entry.valid && (w_f_entry.tag == w_f_tag);

  assign io_bus.f_pred_taken  = w_f_hit && (w_f_entry.is_jump || w_f_entry.ctr[1]);
  assign io_bus.f_pred_target = w_f_entry.target;

  // EX resolution
  logic [31:0] w_pc_ext;
  logic [31:0] w_pc_imm;
  logic [31:0] w_pc_four;
  logic [31:0] w_actual_target;
  logic        w_actual_taken;
  logic        w_resolve;
  logic        w_mispredict;
  logic        w_redirect;

  assign w_pc_ext        = {{(32-PC_W){1'b0}}, io_bus.ex_pc};
  assign w_pc_imm        = w_pc_ext + io_bus.ex_imm;
  assign w_pc_four       = w_pc_ext + 32'd4;
  assign w_resolve       = io_bus.ex_valid &&
                           (io_bus.ex_branch || io_bus.ex_jmp || io_bus.ex_jmpr);
  assign w_actual_taken  = (io_bus.ex_branch && io_bus.ex_alu_result[0]) ||
                           io_bus.ex_jmp || io_bus.ex_jmpr;
  assign w_actual_target = io_bus.ex_jmpr ? {io_bus.ex_alu_result[31:1], 1'b0} : w_pc_imm;
  // Only the low PC_W bits of the target are predicted, so only those are compared.
  assign w_mispredict    = (w_actual_taken != io_bus.ex_pred_taken) ||
                           (w_actual_taken &&
                            (io_bus.ex_pred_target != w_actual_target[PC_W-1:0]));
  assign w_redirect      = w_resolve && w_mispredict;

  assign io_bus.pc_imm           = w_pc_imm;
  assign io_bus.pc_four          = w_pc_four;
  assign io_bus.redirect         = w_redirect;
  assign io_bus.redirect_pc      = w_actual_taken ? w_actual_target : w_pc_four;
  assign io_bus.perf_branches    = r_perf_branches;
  assign io_bus.perf_mispredicts = r_perf_mispredicts;

  // Training
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  entry_t           w_ex_entry;
  logic             w_ex_hit;
  ctr_e             w_next_ctr;
  logic             w_wr_en;
  entry_t           w_wr_entry;

  assign w_ex_idx   = io_bus.ex_pc[IDX_W+1:2];
  assign w_ex_tag   = io_bus.ex_pc[PC_W-1:IDX_W+2];
  assign w_ex_entry = r_btb[w_ex_idx];
  assign w_ex_hit   = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);

  bp_sat_ctr2 u_sat_ctr (
    .i_ctr   (w_ex_entry.ctr),
    .i_taken (w_actual_taken),
    .o_ctr   (w_next_ctr)
  );

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_entry = w_ex_entry;
    if (w_resolve) begin
      if (w_ex_hit) begin
        w_wr_en = 1'b1;
        if (io_bus.ex_branch) begin
          w_wr_entry.ctr = w_next_ctr;
          if (w_actual_taken) w_wr_entry.target = w_actual_target[PC_W-1:0];
        end else begin
          w_wr_entry.target  = w_actual_target[PC_W-1:0];
          w_wr_entry.is_jump = 1'b1;
        end
      end else if (w_actual_taken) begin
        // Allocation evicts whatever aliased entry occupies this index.
        w_wr_en            = 1'b1;
        w_wr_entry.valid   = 1'b1;
        w_wr_entry.tag     = w_ex_tag;
        w_wr_entry.target  = w_actual_target[PC_W-1:0];
        w_wr_entry.is_jump = io_bus.ex_jmp || io_bus.ex_jmpr;
        w_wr_entry.ctr     = ALLOC_CTR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_btb[i] <= RESET_ENTRY;
    end else if (w_wr_en) begin
      r_btb[w_ex_idx] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (w_resolve)  r_perf_branches    <= r_perf_branches + 32'd1;
      if (w_redirect) r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
    end
  end

  logic w_unused;
  assign w_unused = ^{io_bus.f_pc[1:0], w_f_entry.ctr[0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed vector bench for branch_predict_unit: BTB training, saturation, aliasing,
// JAL/JALR targets, redirect generation and perf counters with asynchronous reset.
module tb_branch_predict_unit;

  localparam logic [2:0] BR   = 3'b100;
  localparam logic [2:0] JAL  = 3'b010;
  localparam logic [2:0] JALR = 3'b001;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_W(9)) bus ();

  branch_predict_unit #(
    .PC_W        (9),
    .BTB_ENTRIES (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_bus  (bus.slave)
  );

  typedef struct {
    logic [8:0]  f_pc;
    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic [31:0] imm;
    logic [2:0]  kind;
    logic [31:0] alu;
    logic        pt;
    logic [8:0]  ptgt;
    logic        e_fpt;
    logic [8:0]  e_ftgt;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic [31:0] e_pcimm;
    logic [31:0] e_pc4;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [26];

  function automatic vec_t mk(input logic [8:0] f_pc, input logic [8:0] ex_pc,
                              input logic [31:0] imm, input logic [2:0] kind,
                              input logic [31:0] alu, input logic pt, input logic [8:0] ptgt,
                              input logic e_fpt, input logic [8:0] e_ftgt, input logic e_redir,
                              input logic [31:0] e_rpc, input logic [31:0] e_pcimm,
                              input logic [31:0] e_pc4);
    vec_t v;
    v.f_pc = f_pc;   v.ex_valid = 1'b1; v.ex_pc = ex_pc; v.imm = imm; v.kind = kind;
    v.alu = alu;     v.pt = pt;         v.ptgt = ptgt;   v.e_fpt = e_fpt;
    v.e_ftgt = e_ftgt; v.e_redir = e_redir; v.e_rpc = e_rpc;
    v.e_pcimm = e_pcimm; v.e_pc4 = e_pc4;
    return v;
  endfunction

  function automatic vec_t bub(input logic [8:0] f_pc, input logic e_fpt,
                               input logic [8:0] e_ftgt);
    vec_t v;
    v = mk(f_pc, 9'h000, 32'h0, 3'b000, 32'h0, 1'b0, 9'h000, e_fpt, e_ftgt, 1'b0,
           32'h4, 32'h0, 32'h4);
    v.ex_valid = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.f_pc           = v.f_pc;
    bus.ex_valid       = v.ex_valid;
    bus.ex_pc          = v.ex_pc;
    bus.ex_imm         = v.imm;
    bus.ex_branch      = v.kind[2];
    bus.ex_jmp         = v.kind[1];
    bus.ex_jmpr        = v.kind[0];
    bus.ex_alu_result  = v.alu;
    bus.ex_pred_taken  = v.pt;
    bus.ex_pred_target = v.ptgt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    check(name, act, exp);
  endtask

  // Drive after the falling edge, sample mid-low-phase, well before the next rising edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #2;
    n_vec++;
    check({tag, " f_pred_taken"}, 32'(bus.f_pred_taken), 32'(v.e_fpt));
    if (v.e_fpt) check({tag, " f_pred_target"}, 32'(bus.f_pred_target), 32'(v.e_ftgt));
    check({tag, " redirect"}, 32'(bus.redirect), 32'(v.e_redir));
    if (v.ex_valid) check({tag, " redirect_pc"}, bus.redirect_pc, v.e_rpc);
    check({tag, " pc_imm"}, bus.pc_imm, v.e_pcimm);
    check({tag, " pc_four"}, bus.pc_four, v.e_pc4);
  endtask

  initial begin
    tbl[0]  = bub(9'h040, 1'b0, 9'h000);
    tbl[1]  = mk(9'h040, 9'h040, 32'h20, BR, 32'h1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1,
                 32'h60, 32'h60, 32'h44);
    tbl[2]  = bub(9'h040, 1'b1, 9'h060);
    tbl[3]  = mk(9'h040, 9'h040, 32'h20, BR, 32'h0, 1'b1, 9'h060, 1'b1, 9'h060, 1'b1,
                 32'h44, 32'h60, 32'h44);
    tbl[4]  = mk(9'h040, 9'h040, 32'h20, BR, 32'h0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0,
                 32'h44, 32'h60, 32'h44);
    tbl[5]  = tbl[4];
    tbl[6]  = bub(9'h040, 1'b0, 9'h000);
    tbl[7]  = mk(9'h040, 9'h040, 32'h20, BR, 32'h1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1,
                 32'h60, 32'h60, 32'h44);
    tbl[8]  = bub(9'h040, 1'b0, 9'h000);
    tbl[9]  = tbl[7];
    tbl[10] = bub(9'h040, 1'b1, 9'h060);
    tbl[11] = mk(9'h140, 9'h140, 32'h20, BR, 32'h1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1,
                 32'h160, 32'h160, 32'h144);
    tbl[12] = bub(9'h040, 1'b0, 9'h000);
    tbl[13] = bub(9'h140, 1'b1, 9'h160);
    tbl[14] = mk(9'h080, 9'h080, 32'h0, JALR, 32'h123, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1,
                 32'h122, 32'h80, 32'h84);
    tbl[15] = bub(9'h080, 1'b1, 9'h122);
    tbl[16] = mk(9'h080, 9'h080, 32'h0, JALR, 32'h123, 1'b1, 9'h122, 1'b1, 9'h122, 1'b0,
                 32'h122, 32'h80, 32'h84);
    tbl[17] = mk(9'h080, 9'h080, 32'h0, BR, 32'h0, 1'b1, 9'h122, 1'b1, 9'h122, 1'b1,
                 32'h84, 32'h80, 32'h84);
    tbl[18] = bub(9'h080, 1'b1, 9'h122);
    tbl[19] = mk(9'h0C4, 9'h0C4, 32'hFFFF_FFF0, JAL, 32'h0, 1'b1, 9'h0B4, 1'b0, 9'h000, 1'b0,
                 32'hB4, 32'hB4, 32'hC8);
    tbl[20] = bub(9'h0C4, 1'b1, 9'h0B4);
    tbl[21] = mk(9'h0C4, 9'h0C4, 32'hFFFF_FFF0, JAL, 32'h0, 1'b1, 9'h0B0, 1'b1, 9'h0B4, 1'b1,
                 32'hB4, 32'hB4, 32'hC8);
    tbl[22] = mk(9'h108, 9'h108, 32'h0, JALR, 32'h1234_5679, 1'b1, 9'h078, 1'b0, 9'h000, 1'b0,
                 32'h1234_5678, 32'h108, 32'h10C);
    tbl[23] = bub(9'h10B, 1'b1, 9'h078);
    tbl[24] = mk(9'h040, 9'h040, 32'h20, BR, 32'h1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0,
                 32'h60, 32'h60, 32'h44);
    tbl[24].ex_valid = 1'b0;
    tbl[25] = bub(9'h040, 1'b0, 9'h000);

    drive(bub(9'h040, 1'b0, 9'h000));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_now("reset perf_branches", bus.perf_branches, 32'd0);
    check_now("reset perf_mispredicts", bus.perf_mispredicts, 32'd0);

    for (int i = 0; i < 26; i++) apply(tbl[i], $sformatf("vec%0d", i));

    check_now("table perf_branches", bus.perf_branches, 32'd13);
    check_now("table perf_mispredicts", bus.perf_mispredicts, 32'd8);

    // Asynchronous reset while a taken-miss resolution is live: no count, no allocation.
    @(negedge clk);
    drive(mk(9'h108, 9'h1C0, 32'h8, BR, 32'h1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1,
             32'h1C8, 32'h1C8, 32'h1C4));
    #1 reset_n = 1'b0;
    #1;
    check_now("async rst perf_branches", bus.perf_branches, 32'd0);
    check_now("async rst perf_mispredicts", bus.perf_mispredicts, 32'd0);
    check_now("async rst f_pred_taken", 32'(bus.f_pred_taken), 32'd0);
    check_now("in rst redirect", 32'(bus.redirect), 32'd1);
    check_now("in rst redirect_pc", bus.redirect_pc, 32'h1C8);
    @(posedge clk);
    #1;
    check_now("held rst perf_branches", bus.perf_branches, 32'd0);
    @(negedge clk);
    drive(bub(9'h1C0, 1'b0, 9'h000));
    reset_n = 1'b1;

    // Five resolutions, two redirects, bubbles between them.
    apply(mk(9'h1C0, 9'h1C0, 32'h8, BR, 32'h0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0,
             32'h1C4, 32'h1C8, 32'h1C4), "cnt r1");
    apply(bub(9'h1C0, 1'b0, 9'h000), "cnt b1");
    apply(mk(9'h1C0, 9'h1C0, 32'h8, BR, 32'h0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0,
             32'h1C4, 32'h1C8, 32'h1C4), "cnt r2");
    apply(bub(9'h1C0, 1'b0, 9'h000), "cnt b2");
    apply(mk(9'h1C0, 9'h1C0, 32'h8, BR, 32'h1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1,
             32'h1C8, 32'h1C8, 32'h1C4), "cnt r3");
    apply(bub(9'h1C0, 1'b1, 9'h1C8), "cnt b3");
    apply(mk(9'h1C0, 9'h1C0, 32'h8, BR, 32'h1, 1'b1, 9'h1C8, 1'b1, 9'h1C8, 1'b0,
             32'h1C8, 32'h1C8, 32'h1C4), "cnt r4");
    apply(bub(9'h1C0, 1'b1, 9'h1C8), "cnt b4");
    apply(mk(9'h1C0, 9'h1C0, 32'h8, BR, 32'h0, 1'b1, 9'h1C8, 1'b1, 9'h1C8, 1'b1,
             32'h1C4, 32'h1C8, 32'h1C4), "cnt r5");
    apply(bub(9'h1C0, 1'b1, 9'h1C8), "cnt b5");
    check_now("count perf_branches", bus.perf_branches, 32'd5);
    check_now("count perf_mispredicts", bus.perf_mispredicts, 32'd2);

    // Short reset pulse between clock edges.
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_now("pulse perf_branches", bus.perf_branches, 32'd0);
    check_now("pulse perf_mispredicts", bus.perf_mispredicts, 32'd0);
    check_now("pulse f_pred_taken", 32'(bus.f_pred_taken), 32'd0);
    #1 reset_n = 1'b1;
    apply(bub(9'h1C0, 1'b0, 9'h000), "post pulse");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the EX-stage branch resolver. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and 32-bit performance counters. The fetch stage queries the BTB combinationally for a next-PC prediction. The EX stage resolves the branch or jump, computes PC+imm and PC+4, flags a misprediction with a redirect target, and trains the BTB on the following clock edge.

## Interface
Parameters:
- PC_W, 9, PC width in bits; stored targets and tags are derived from it.
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2.
- IDX_W, $clog2(BTB_ENTRIES), index width; derived, not overridden.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- f_pc  in  PC_W  fetch PC.
- f_pred_taken  out  1  prediction that the fetch PC redirects.
- f_pred_target  out  PC_W  predicted target; valid when f_pred_taken=1.
- ex_valid  in  1  EX instruction is valid (not a bubble or flush).
- ex_pc  in  PC_W  EX instruction PC.
- ex_imm  in  32  sign-extended immediate.
- ex_branch, ex_jmp, ex_jmpr  in  1 each  conditional branch, JAL, JALR; at most one is set.
- ex_alu_result  in  32  bit 0 is the compare outcome for branches; the full value is the JALR target.
- ex_pred_taken  in  1  fetch prediction carried down the pipe for this instruction.
- ex_pred_target  in  PC_W  fetch target carried down the pipe for this instruction.
- pc_imm, pc_four  out  32  {zero-ext ex_pc}+ex_imm and {zero-ext ex_pc}+4.
- redirect  out  1  misprediction; fetch must load redirect_pc and flush younger instructions.
- redirect_pc  out  32  correct next PC.
- perf_branches, perf_mispredicts  out  32 each  resolved control-flow count and mispredict count.

## Operation
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[PC_W-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target[PC_W-1:0], is_jump, ctr[1:0].
- Lookup:
  - hit = valid && tag match.
  - f_pred_taken = hit && (is_jump || ctr[1]).
  - f_pred_target = entry target.
- Resolution applies only when ex_valid=1 and one of ex_branch/ex_jmp/ex_jmpr is set. Otherwise redirect=0, nothing trains, and nothing counts.
- actual_taken = (ex_branch && ex_alu_result[0]) || ex_jmp || ex_jmpr.
- actual_target:
  - JALR: ex_alu_result with bit 0 cleared.
  - Otherwise: pc_imm.
- redirect_pc: actual_target if actual_taken, else pc_four.
- redirect = (actual_taken != ex_pred_taken) || (actual_taken && ex_pred_target != actual_target[PC_W-1:0]).
- redirect_pc bits above PC_W pass through unchanged; only the low PC_W bits are compared and stored.
- Training, at the clock edge after resolution:
  - Hit, conditional branch: ctr saturates toward taken or not-taken per actual_taken (11 and 00 hold). If taken, the target is rewritten.
  - Hit, jump (JAL or JALR): target rewritten, is_jump=1.
  - Miss, actual_taken: the entry is allocated (overwriting any occupant). valid=1, tag, target written; is_jump=ex_jmp|ex_jmpr; ctr=10 (weak taken).
  - Miss, not taken: no allocation.
- perf_branches increments by 1 per resolution. perf_mispredicts increments by 1 per redirect=1. Both wrap at 2^32.

## Timing
- Lookup outputs are combinational from f_pc and BTB state.
- pc_imm, pc_four, redirect and redirect_pc are combinational from EX inputs, with zero added latency, matching the previous-generation resolver.
- BTB and perf counters update on the rising clk edge at the end of the resolve cycle. Lookups see the update one cycle later.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update entry. There is no bypass.
- Reset (reset_n=0, asynchronous, any cycle including mid-update):
  - All valid=0, ctr=01, targets=0, perf counters=0.
  - f_pred_taken=0 from then on until training.
  - redirect depends only on EX inputs.
  - No write occurs while reset is asserted.
- Index aliasing: the tag mismatch forces a miss. A taken resolution replaces the aliased entry.

## Structure
- bp_pkg holds:
  - the ctr_e enum: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - the btb_entry_t packed struct (valid, tag, target, is_jump, ctr);
  - the RESET_CTR=WNT and ALLOC_CTR=WT constants.
- Tag and target widths are parameter-dependent and live in the module as localparams. The struct uses them via a parameterised typedef inside the module.
- One sub-module, bp_sat_ctr2: combinational next-state from ctr_e and taken. This keeps saturation testable in isolation.

## Test plan
- Reset, then f_pc=0x040: f_pred_taken=0, perf counters=0.
- Taken BEQ at ex_pc=0x040, imm=+0x20, ex_pred_taken=0:
  - Same cycle: redirect=1, redirect_pc=0x060.
  - Next cycle, f_pc=0x040: f_pred_taken=1, target=0x060.
- Same BEQ resolved not-taken three times with correct predictions fed back:
  - ctr goes 10→01→00→00.
  - The first not-taken resolution (predicted taken) gives redirect=1, redirect_pc=0x044.
  - Afterwards f_pred_taken=0.
- JALR at 0x080 with alu_result=0x0000_0123, ex_pred_taken=0: redirect_pc=0x122, redirect=1, entry is_jump=1. A repeat with pred target 0x122 gives redirect=0.
- Aliasing with PC_W=9, 16 entries: train 0x040 taken, then resolve taken 0x140 (same idx, different tag). Lookup of 0x040 misses; lookup of 0x140 hits.
- Counting: 5 resolutions with 2 redirects, plus bubbles (ex_valid=0) between them: perf_branches=5, perf_mispredicts=2. A reset_n pulse mid-sequence returns both to 0 asynchronously.
